// File: rtl/irq_controller_pkg.sv
// Shared types and helpers for the interrupt source controller.
package irq_controller_pkg;

   localparam int IRQ_SRC_COUNT = 4;

   typedef logic [IRQ_SRC_COUNT-1:0] irq_vec_t;

   typedef enum logic [1:0] {
      IRQC_IDLE    = 2'd0,
      IRQC_REQ     = 2'd1,
      IRQC_SERVICE = 2'd2
   } irqc_state_t;

   // Isolate the lowest set bit; bit 0 is the highest-priority source.
   function automatic irq_vec_t lowest_set(input irq_vec_t v);
      return v & (~v + irq_vec_t'(1));
   endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one asynchronous request line, with a
// registered previous value feeding a rising-edge detect.
module irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise
);

   // SYNC_STAGES must be at least 2; the slice below relies on it.
   logic [SYNC_STAGES-1:0] r_chain;
   logic                   r_prev;

   // Shift the raw line through the chain and remember the last synced value.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_chain <= '0;
         r_prev  <= 1'b0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
         r_prev  <= r_chain[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_chain[SYNC_STAGES-1];
   assign o_rise = r_chain[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// Interrupt source side of the CPU handshake: synchronise requests, latch
// them as pending, raise irq for the highest-priority enabled source and
// present the serviced source as a one-hot cause until end-of-interrupt.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int                       SYNC_STAGES = 2,
   parameter logic [IRQ_SRC_COUNT-1:0] EDGE_MASK   = 4'b1111
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [IRQ_SRC_COUNT-1:0] src,
   input  logic [IRQ_SRC_COUNT-1:0] ie,
   input  logic                     ack,
   input  logic                     eoi,
   output logic                     irq,
   output logic [IRQ_SRC_COUNT-1:0] cause,
   output logic [IRQ_SRC_COUNT-1:0] lost
);

   irq_vec_t    w_sync;
   irq_vec_t    w_rise;
   irq_vec_t    w_sel;
   irq_vec_t    w_clr;

   irq_vec_t    r_pending;
   irq_vec_t    r_lost;
   irq_vec_t    r_held;
   irq_vec_t    r_cause;
   logic        r_irq;
   irqc_state_t r_state;

   genvar g;
   generate
      for (g = 0; g < IRQ_SRC_COUNT; g++) begin : g_sync
         irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
         ) u_sync (
            .clock  (clock),
            .reset  (reset),
            .i_async(src[g]),
            .o_sync (w_sync[g]),
            .o_rise (w_rise[g])
         );
      end
   endgenerate

   assign w_sel = lowest_set(r_pending & ie);
   // Only an eoi that ends a service clears anything, and only the served source.
   assign w_clr = (r_state == IRQC_SERVICE && eoi) ? r_cause : '0;

   // Pending and lost tracking; a new edge beats a same-cycle clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pending <= '0;
         r_lost    <= '0;
      end else begin
         for (int i = 0; i < IRQ_SRC_COUNT; i++) begin
            if (EDGE_MASK[i]) begin
               if (w_rise[i])
                  r_pending[i] <= 1'b1;
               else if (w_clr[i])
                  r_pending[i] <= 1'b0;

               if (w_clr[i])
                  r_lost[i] <= 1'b0;
               else if (w_rise[i] && r_pending[i])
                  r_lost[i] <= 1'b1;
            end else begin
               r_pending[i] <= w_sync[i];
               r_lost[i]    <= 1'b0;
            end
         end
      end
   end

   // Handshake FSM: the selection is frozen once irq is raised.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IRQC_IDLE;
         r_irq   <= 1'b0;
         r_held  <= '0;
         r_cause <= '0;
      end else begin
         case (r_state)
            IRQC_IDLE: begin
               if (w_sel != '0) begin
                  r_held  <= w_sel;
                  r_irq   <= 1'b1;
                  r_state <= IRQC_REQ;
               end else begin
                  r_irq <= 1'b0;
               end
            end
            IRQC_REQ: begin
               if (ack) begin
                  r_irq   <= 1'b0;
                  r_cause <= r_held;
                  r_state <= IRQC_SERVICE;
               end
            end
            IRQC_SERVICE: begin
               if (eoi) begin
                  r_cause <= '0;
                  r_state <= IRQC_IDLE;
               end
            end
            default: begin
               r_state <= IRQC_IDLE;
               r_irq   <= 1'b0;
               r_cause <= '0;
            end
         endcase
      end
   end

   assign irq   = r_irq;
   assign cause = r_cause;
   assign lost  = r_lost;

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: directed handshake scenarios followed by a
// randomized run compared against a behavioural model.
module tb_irq_controller;

   localparam int         SYNC  = 2;
   localparam logic [3:0] EMASK = 4'b1111;

   localparam int PH_IDLE    = 0;
   localparam int PH_REQ     = 1;
   localparam int PH_SERVICE = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] src;
   logic [3:0] ie;
   logic       ack;
   logic       eoi;
   logic       irq;
   logic [3:0] cause;
   logic [3:0] lost;

   int tests;
   int fails;

   // Behavioural model state
   logic [3:0] m_hist [0:SYNC];
   logic [3:0] m_pend;
   logic [3:0] m_lost;
   logic [3:0] m_held;
   logic [3:0] m_cause;
   logic       m_irq;
   int         m_phase;

   irq_controller #(
      .SYNC_STAGES(SYNC),
      .EDGE_MASK  (EMASK)
   ) dut (
      .clock(clock),
      .reset(reset),
      .src  (src),
      .ie   (ie),
      .ack  (ack),
      .eoi  (eoi),
      .irq  (irq),
      .cause(cause),
      .lost (lost)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge of the reference behaviour, using the inputs seen at the edge.
   task automatic model_edge();
      logic [3:0] s, rise, pe, sel, clr;
      if (reset) begin
         for (int i = 0; i <= SYNC; i++) m_hist[i] = 4'h0;
         m_pend  = 4'h0;
         m_lost  = 4'h0;
         m_held  = 4'h0;
         m_cause = 4'h0;
         m_irq   = 1'b0;
         m_phase = PH_IDLE;
         return;
      end
      s    = m_hist[SYNC-1];
      rise = s & ~m_hist[SYNC];
      pe   = m_pend & ie;
      sel  = 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (pe[i]) begin
            sel[i] = 1'b1;
            break;
         end
      end
      clr = (m_phase == PH_SERVICE && eoi) ? m_cause : 4'h0;
      for (int i = 0; i < 4; i++) begin
         if (EMASK[i]) begin
            if (clr[i]) m_lost[i] = 1'b0;
            else if (rise[i] && m_pend[i]) m_lost[i] = 1'b1;
            if (rise[i]) m_pend[i] = 1'b1;
            else if (clr[i]) m_pend[i] = 1'b0;
         end else begin
            m_pend[i] = s[i];
            m_lost[i] = 1'b0;
         end
      end
      case (m_phase)
         PH_IDLE: begin
            if (sel != 4'h0) begin
               m_held  = sel;
               m_irq   = 1'b1;
               m_phase = PH_REQ;
            end
         end
         PH_REQ: begin
            if (ack) begin
               m_irq   = 1'b0;
               m_cause = m_held;
               m_phase = PH_SERVICE;
            end
         end
         default: begin
            if (eoi) begin
               m_cause = 4'h0;
               m_phase = PH_IDLE;
            end
         end
      endcase
      for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = src;
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic wait_irq(input string tag);
      int n;
      n = 0;
      while (irq !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, {3'b000, irq}, 4'h1);
   endtask

   task automatic serve(input string tag, input logic [3:0] exp_cause);
      wait_irq(tag);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk(tag, cause, exp_cause);
      chk(tag, {3'b000, irq}, 4'h0);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      chk(tag, cause, 4'h0);
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      for (int i = 0; i <= SYNC; i++) m_hist[i] = 4'h0;
      m_pend  = 4'h0;
      m_lost  = 4'h0;
      m_held  = 4'h0;
      m_cause = 4'h0;
      m_irq   = 1'b0;
      m_phase = PH_IDLE;

      // Reset with all requests high
      reset = 1'b1; src = 4'hF; ie = 4'hF; ack = 1'b0; eoi = 1'b0;
      tick(); tick();
      chk("rst_irq",   {3'b000, irq}, 4'h0);
      chk("rst_cause", cause, 4'h0);
      chk("rst_lost",  lost, 4'h0);
      reset = 1'b0;
      tick(); tick(); tick();
      chk("rst_lat_early", {3'b000, irq}, 4'h0);
      tick();
      chk("rst_lat_rise", {3'b000, irq}, 4'h1);
      src = 4'h0;
      serve("rst_s0", 4'b0001);
      serve("rst_s1", 4'b0010);
      serve("rst_s2", 4'b0100);
      serve("rst_s3", 4'b1000);
      repeat (4) tick();
      chk("rst_drained", {3'b000, irq}, 4'h0);
      chk("rst_nolost", lost, 4'h0);

      // Basic handshake on source 2
      src = 4'b0100;
      tick();
      src = 4'h0;
      tick(); tick();
      chk("basic_lat_early", {3'b000, irq}, 4'h0);
      tick();
      chk("basic_irq", {3'b000, irq}, 4'h1);
      tick();
      chk("basic_irq_hold", {3'b000, irq}, 4'h1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("basic_cause", cause, 4'b0100);
      chk("basic_irq_low", {3'b000, irq}, 4'h0);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      chk("basic_cause_clr", cause, 4'h0);
      repeat (5) tick();
      chk("basic_no_reirq", {3'b000, irq}, 4'h0);

      // Priority between sources 1 and 3
      src = 4'b1010;
      tick();
      src = 4'h0;
      serve("prio_first", 4'b0010);
      serve("prio_second", 4'b1000);
      repeat (4) tick();
      chk("prio_idle", {3'b000, irq}, 4'h0);

      // Masked request released later
      ie = 4'h0;
      src = 4'b0001;
      tick();
      src = 4'h0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("mask_quiet", {3'b000, irq}, 4'h0);
      end
      ie = 4'b0001;
      tick();
      chk("mask_release", {3'b000, irq}, 4'h1);
      serve("mask_serve", 4'b0001);
      ie = 4'hF;

      // Edge on source 1 during its own service
      src = 4'b0010;
      tick();
      src = 4'h0;
      wait_irq("lost_irq");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("lost_cause", cause, 4'b0010);
      src = 4'b0010;
      tick();
      src = 4'h0;
      tick(); tick();
      chk("lost_set", lost, 4'b0010);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      chk("lost_clr", lost, 4'h0);
      chk("lost_cause_clr", cause, 4'h0);
      repeat (4) tick();
      chk("lost_pend_clr", {3'b000, irq}, 4'h0);

      // New edge landing in the eoi cycle
      src = 4'b0010;
      tick();
      src = 4'h0;
      wait_irq("sc_irq");
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("sc_cause", cause, 4'b0010);
      src = 4'b0010;
      tick();
      src = 4'h0;
      tick();
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      chk("sc_lost", lost, 4'h0);
      chk("sc_cause_clr", cause, 4'h0);
      chk("sc_irq_gap", {3'b000, irq}, 4'h0);
      tick();
      chk("sc_reassert", {3'b000, irq}, 4'h1);
      serve("sc_serve", 4'b0010);

      // Reset while a request is outstanding
      src = 4'b0100;
      tick();
      src = 4'h0;
      wait_irq("midrst_irq");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_irq_low", {3'b000, irq}, 4'h0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("midrst_ack_ignored", cause, 4'h0);
      repeat (4) tick();
      chk("midrst_quiet", {3'b000, irq}, 4'h0);

      // Request stays raised after its enable is withdrawn
      src = 4'b1000;
      tick();
      src = 4'h0;
      wait_irq("frozen_irq");
      ie = 4'h0;
      repeat (3) tick();
      chk("frozen_hold", {3'b000, irq}, 4'h1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("frozen_cause", cause, 4'b1000);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      ie = 4'hF;
      chk("frozen_done", cause, 4'h0);

      // Randomized traffic
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 400; k++) begin
         src = 4'($urandom & $urandom & $urandom);
         if (k % 16 == 0) ie = 4'($urandom | $urandom);
         ack   = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         eoi   = (m_phase == PH_SERVICE) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 15) == 0);
         reset = ($urandom_range(0, 199) == 0);
         tick();
         chk("rand_irq",   {3'b000, irq}, {3'b000, m_irq});
         chk("rand_cause", cause, m_cause);
         chk("rand_lost",  lost, m_lost);
      end
      reset = 1'b0; src = 4'h0; ack = 1'b0; eoi = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
